// File: rtl/dmux8_scatter_ctrl_pkg.sv
// Shared constants for the dmux8 scatter sequencer.
// Destination count, select width and state encodings.
package scatter_pkg;

   localparam int DEST_COUNT = 8;
   localparam int SEL_WIDTH  = 3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/dmux8_scatter_ctrl_if.sv
// Producer and consumer handshake bundle of the scatter sequencer.
// slave is the controller side, master is the producer/consumer side.
interface dmux8_scatter_ctrl_if #(
   parameter int BUS_WIDTH = 8
);

   logic                 in_valid;
   logic                 in_ready;
   logic [BUS_WIDTH-1:0] in_data;
   logic [7:0]           in_mask;
   logic [BUS_WIDTH-1:0] out_data0;
   logic [BUS_WIDTH-1:0] out_data1;
   logic [BUS_WIDTH-1:0] out_data2;
   logic [BUS_WIDTH-1:0] out_data3;
   logic [BUS_WIDTH-1:0] out_data4;
   logic [BUS_WIDTH-1:0] out_data5;
   logic [BUS_WIDTH-1:0] out_data6;
   logic [BUS_WIDTH-1:0] out_data7;
   logic [7:0]           out_valid;
   logic [7:0]           dest_ready;

   modport slave (
      input  in_valid, in_data, in_mask, dest_ready,
      output in_ready, out_valid,
      output out_data0, out_data1, out_data2, out_data3,
      output out_data4, out_data5, out_data6, out_data7
   );

   modport master (
      output in_valid, in_data, in_mask, dest_ready,
      input  in_ready, out_valid,
      input  out_data0, out_data1, out_data2, out_data3,
      input  out_data4, out_data5, out_data6, out_data7
   );

endinterface

// File: rtl/dmux8.sv
// 1-to-8 demultiplexer: the selected output carries d, all others are 0.
// Purely combinational.
module dmux8 #(
   parameter int BUS_WIDTH = 8
) (
   input  logic [BUS_WIDTH-1:0] d,
   input  logic [2:0]           sel,
   output logic [BUS_WIDTH-1:0] y0,
   output logic [BUS_WIDTH-1:0] y1,
   output logic [BUS_WIDTH-1:0] y2,
   output logic [BUS_WIDTH-1:0] y3,
   output logic [BUS_WIDTH-1:0] y4,
   output logic [BUS_WIDTH-1:0] y5,
   output logic [BUS_WIDTH-1:0] y6,
   output logic [BUS_WIDTH-1:0] y7
);

   always_comb begin
      y0 = '0;
      y1 = '0;
      y2 = '0;
      y3 = '0;
      y4 = '0;
      y5 = '0;
      y6 = '0;
      y7 = '0;
      unique case (sel)
         3'd0: y0 = d;
         3'd1: y1 = d;
         3'd2: y2 = d;
         3'd3: y3 = d;
         3'd4: y4 = d;
         3'd5: y5 = d;
         3'd6: y6 = d;
         3'd7: y7 = d;
         default: y0 = d;
      endcase
   end

endmodule

// File: rtl/dmux8_scatter_ctrl_lowest_set8.sv
// Lowest-set-bit priority encoder over 8 bits.
// idx is 0 and none is high when the mask is empty.
module lowest_set8
   import scatter_pkg::*;
(
   input  logic [DEST_COUNT-1:0] mask,
   output logic [SEL_WIDTH-1:0]  idx,
   output logic                  none
);

   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      idx  = '0;
      none = 1'b1;
      for (int i = DEST_COUNT - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx  = SEL_WIDTH'(i);
            none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/dmux8_scatter_ctrl.sv
// Scatters one word to every destination in a mask, lowest first,
// with a per-destination handshake and an optional stall timeout.
module dmux8_scatter_ctrl
   import scatter_pkg::*;
#(
   parameter int BUS_WIDTH = 8,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dmux8_scatter_ctrl_if.slave  bus,
   output logic [SEL_WIDTH-1:0] sel,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           skipped_mask
);

   localparam bit         TMO_EN   = (TIMEOUT != 0);
   localparam logic [7:0] TMO_LAST = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;

   logic [0:0]            state_q;
   logic [BUS_WIDTH-1:0]  data_q;
   logic [DEST_COUNT-1:0] pend_q;
   logic [SEL_WIDTH-1:0]  sel_q;
   logic [7:0]            wait_q;
   logic [DEST_COUNT-1:0] skip_q;
   logic                  done_q;

   logic [SEL_WIDTH-1:0]  acc_idx;
   logic                  acc_none;
   logic [SEL_WIDTH-1:0]  adv_idx;
   logic                  adv_none;
   logic [DEST_COUNT-1:0] cur_bit;
   logic [DEST_COUNT-1:0] pend_rem;
   logic                  hit;
   logic                  tmo;
   logic                  step;
   logic [BUS_WIDTH-1:0]  dmux_in;

   assign cur_bit  = DEST_COUNT'(1) << sel_q;
   assign pend_rem = pend_q & ~cur_bit;
   assign hit      = |(bus.dest_ready & cur_bit);
   assign tmo      = TMO_EN && (wait_q == TMO_LAST);
   assign step     = hit | tmo;

   lowest_set8 u_acc (
      .mask (bus.in_mask),
      .idx  (acc_idx),
      .none (acc_none)
   );

   lowest_set8 u_adv (
      .mask (pend_rem),
      .idx  (adv_idx),
      .none (adv_none)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         pend_q  <= '0;
         sel_q   <= '0;
         wait_q  <= '0;
         skip_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  data_q <= bus.in_data;
                  skip_q <= '0;
                  if (acc_none) begin
                     done_q <= 1'b1;
                  end else begin
                     pend_q  <= bus.in_mask;
                     sel_q   <= acc_idx;
                     wait_q  <= '0;
                     state_q <= ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               if (step) begin
                  pend_q <= pend_rem;
                  wait_q <= '0;
                  sel_q  <= adv_idx;
                  if (!hit) skip_q[sel_q] <= 1'b1;
                  if (adv_none) begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy         = (state_q == ST_SEND);
   assign bus.in_ready = (state_q == ST_IDLE);
   assign sel          = sel_q;
   assign done         = done_q;
   assign skipped_mask = skip_q;

   // Outside SEND the dmux sees 0, so idle outputs are quiet.
   assign dmux_in = busy ? data_q : '0;

   dmux8 #(.BUS_WIDTH(BUS_WIDTH)) u_data (
      .d   (dmux_in),
      .sel (sel_q),
      .y0  (bus.out_data0),
      .y1  (bus.out_data1),
      .y2  (bus.out_data2),
      .y3  (bus.out_data3),
      .y4  (bus.out_data4),
      .y5  (bus.out_data5),
      .y6  (bus.out_data6),
      .y7  (bus.out_data7)
   );

   dmux8 #(.BUS_WIDTH(1)) u_valid (
      .d   (busy),
      .sel (sel_q),
      .y0  (bus.out_valid[0]),
      .y1  (bus.out_valid[1]),
      .y2  (bus.out_valid[2]),
      .y3  (bus.out_valid[3]),
      .y4  (bus.out_valid[4]),
      .y5  (bus.out_valid[5]),
      .y6  (bus.out_valid[6]),
      .y7  (bus.out_valid[7])
   );

endmodule

// File: tb/tb_dmux8_scatter_ctrl.sv
// Directed bench for dmux8_scatter_ctrl with a delivery/done scoreboard.
// Short timeout so the skip path is reachable quickly.
module tb_dmux8_scatter_ctrl;

   localparam int W   = 8;
   localparam int TMO = 4;

   typedef struct packed {
      logic [2:0]   dest;
      logic [W-1:0] data;
   } deliv_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmux8_scatter_ctrl_if #(.BUS_WIDTH(W)) ifc ();

   logic [2:0] sel;
   logic       busy;
   logic       done;
   logic [7:0] skipped_mask;

   dmux8_scatter_ctrl #(.BUS_WIDTH(W), .TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (ifc.slave),
      .sel          (sel),
      .busy         (busy),
      .done         (done),
      .skipped_mask (skipped_mask)
   );

   int errors = 0;
   int checks = 0;

   deliv_t     dq[$];
   logic [7:0] sq[$];

   logic [W-1:0] obus [8];
   always_comb begin
      obus[0] = ifc.out_data0;
      obus[1] = ifc.out_data1;
      obus[2] = ifc.out_data2;
      obus[3] = ifc.out_data3;
      obus[4] = ifc.out_data4;
      obus[5] = ifc.out_data5;
      obus[6] = ifc.out_data6;
      obus[7] = ifc.out_data7;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [W-1:0] d, input logic [7:0] m);
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      ifc.in_mask  = m;
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
   endtask

   task automatic push_deliv(input logic [W-1:0] d, input logic [7:0] m);
      deliv_t e;
      for (int k = 0; k < 8; k++) begin
         if (m[k]) begin
            e.dest = 3'(k);
            e.data = d;
            dq.push_back(e);
         end
      end
   endtask

   task automatic chk_reset_state(input string tag);
      logic [W-1:0] any_data;
      any_data = '0;
      for (int k = 0; k < 8; k++) any_data |= obus[k];
      chk({tag, "_valid"}, 32'(ifc.out_valid), 32'h0);
      chk({tag, "_data"},  32'(any_data), 32'h0);
      chk({tag, "_sel"},   32'(sel), 32'h0);
      chk({tag, "_busy"},  32'(busy), 32'h0);
      chk({tag, "_ready"}, 32'(ifc.in_ready), 32'h1);
      chk({tag, "_done"},  32'(done), 32'h0);
   endtask

   // Scoreboard: every accepted hand-off and every done pulse is popped here.
   always @(negedge clk) begin
      if (rst_n) begin
         if (|(ifc.out_valid & ifc.dest_ready)) begin
            if (dq.size() == 0) begin
               chk("deliv_unexpected", 32'(ifc.out_valid), 32'h0);
            end else begin
               deliv_t e;
               logic [W-1:0] others;
               e = dq.pop_front();
               others = '0;
               for (int k = 0; k < 8; k++)
                  if (k != int'(e.dest)) others |= obus[k];
               chk("deliv_valid", 32'(ifc.out_valid), 32'(8'h1 << e.dest));
               chk("deliv_data", 32'(obus[e.dest]), 32'(e.data));
               chk("deliv_others", 32'(others), 32'h0);
            end
         end
         if (done) begin
            if (sq.size() == 0) begin
               chk("done_unexpected", 32'(done), 32'h0);
            end else begin
               chk("done_skipped", 32'(skipped_mask), 32'(sq.pop_front()));
            end
         end
      end
   end

   initial begin
      ifc.in_valid   = 1'b1;
      ifc.in_data    = 8'h33;
      ifc.in_mask    = 8'hFF;
      ifc.dest_ready = 8'hFF;

      // Reset held with a live producer: nothing may be latched.
      repeat (3) @(negedge clk);
      chk_reset_state("rst");
      chk("rst_skipped", 32'(skipped_mask), 32'h0);
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_state("post_rst");

      // Three destinations, all ready.
      push_deliv(8'hA5, 8'b1001_0010);
      sq.push_back(8'h00);
      accept(8'hA5, 8'b1001_0010);
      for (int k = 0; k < 8; k++) begin
         logic [7:0] m;
         m = 8'b1001_0010;
         if (m[k]) begin
            @(negedge clk);
            chk("t1_sel", 32'(sel), 32'(k));
            chk("t1_busy", 32'(busy), 32'h1);
            chk("t1_inready", 32'(ifc.in_ready), 32'h0);
         end
      end
      @(negedge clk);
      chk("t1_done", 32'(done), 32'h1);
      chk("t1_inready_done", 32'(ifc.in_ready), 32'h1);
      chk("t1_valid_done", 32'(ifc.out_valid), 32'h0);
      @(negedge clk);
      chk("t1_done_pulse", 32'(done), 32'h0);

      // Single destination stalled for three cycles.
      ifc.dest_ready = 8'h00;
      push_deliv(8'h3C, 8'h04);
      sq.push_back(8'h00);
      accept(8'h3C, 8'h04);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t2_stall_valid", 32'(ifc.out_valid), 32'h04);
         chk("t2_stall_data", 32'(ifc.out_data2), 32'h3C);
      end
      @(posedge clk);
      #1;
      ifc.dest_ready = 8'hFF;
      @(negedge clk);
      chk("t2_xfer_valid", 32'(ifc.out_valid), 32'h04);
      @(negedge clk);
      chk("t2_done", 32'(done), 32'h1);
      chk("t2_busy", 32'(busy), 32'h0);

      // Destination 0 never ready: skipped after TMO cycles.
      ifc.dest_ready = 8'h02;
      push_deliv(8'h5A, 8'h02);
      sq.push_back(8'h01);
      accept(8'h5A, 8'h03);
      for (int c = 0; c < TMO; c++) begin
         @(negedge clk);
         chk("t3_wait_valid", 32'(ifc.out_valid), 32'h01);
      end
      @(negedge clk);
      chk("t3_next_valid", 32'(ifc.out_valid), 32'h02);
      @(negedge clk);
      chk("t3_done", 32'(done), 32'h1);
      @(negedge clk);
      chk("t3_skip_hold", 32'(skipped_mask), 32'h01);

      // Empty mask: consumed, done only, skip record cleared.
      ifc.dest_ready = 8'hFF;
      sq.push_back(8'h00);
      accept(8'h77, 8'h00);
      @(negedge clk);
      chk("t4_done", 32'(done), 32'h1);
      chk("t4_valid", 32'(ifc.out_valid), 32'h0);
      chk("t4_inready", 32'(ifc.in_ready), 32'h1);
      chk("t4_busy", 32'(busy), 32'h0);

      // Reset during the second destination of a full mask.
      push_deliv(8'hC3, 8'h01);
      accept(8'hC3, 8'hFF);
      @(negedge clk);
      chk("t5_sel0", 32'(sel), 32'h0);
      @(posedge clk);
      #2;
      chk("t5_sel1", 32'(sel), 32'h1);
      chk("t5_data1", 32'(ifc.out_data1), 32'hC3);
      rst_n = 1'b0;
      #1;
      chk_reset_state("t5_async");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_no_done", 32'(done), 32'h0);
      chk("t5_idle", 32'(busy), 32'h0);

      // Normal operation after the abandoned scatter.
      push_deliv(8'h11, 8'h81);
      sq.push_back(8'h00);
      accept(8'h11, 8'h81);
      @(negedge clk);
      chk("t6_sel_first", 32'(sel), 32'h0);
      @(negedge clk);
      chk("t6_sel_last", 32'(sel), 32'h7);
      @(negedge clk);
      chk("t6_done", 32'(done), 32'h1);

      repeat (2) @(negedge clk);
      chk("deliv_queue_empty", 32'(dq.size()), 32'h0);
      chk("done_queue_empty", 32'(sq.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
